// File: rtl/fir_ss_fifo.sv
// First-word-fall-through AXI4-Stream buffer ahead of the FIR ss port.
// Registered handshakes, separate level counter, tlast-framed sample counter.
module fir_ss_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   in_flush,
  input  logic                   in_s_tvalid,
  input  logic [pDATA_WIDTH-1:0] in_s_tdata,
  input  logic                   in_s_tlast,
  output logic                   out_s_tready,
  output logic                   out_m_tvalid,
  output logic [pDATA_WIDTH-1:0] out_m_tdata,
  output logic                   out_m_tlast,
  input  logic                   in_m_tready,
  output logic [DEPTH_LOG2:0]    out_level,
  output logic [15:0]            out_frame_cnt,
  output logic                   out_frame_done
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [pDATA_WIDTH:0]  mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  s_rdy_q, s_rdy_d;
  logic                  m_vld_q, m_vld_d;
  logic [15:0]           fcnt_q, fcnt_d;
  logic                  fdone_q, fdone_d;
  logic                  push, pop;
  logic [pDATA_WIDTH:0]  head;

  assign push = in_s_tvalid & s_rdy_q;
  assign pop  = m_vld_q & in_m_tready;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    fcnt_d   = fcnt_q;
    fdone_d  = 1'b0;
    s_rdy_d  = s_rdy_q;
    m_vld_d  = m_vld_q;
    if (in_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      fcnt_d   = '0;
      s_rdy_d  = 1'b1;
      m_vld_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (pop) begin
        if (head[pDATA_WIDTH]) begin
          fcnt_d  = '0;
          fdone_d = 1'b1;
        end else if (fcnt_q != '1) begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      // Handshake flags come from next-state level so neither output is combinational.
      s_rdy_d = (level_d != LVL_FULL);
      m_vld_d = (level_d != '0);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      s_rdy_q  <= 1'b0;
      m_vld_q  <= 1'b0;
      fcnt_q   <= '0;
      fdone_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      s_rdy_q  <= s_rdy_d;
      m_vld_q  <= m_vld_d;
      fcnt_q   <= fcnt_d;
      fdone_q  <= fdone_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push && !in_flush) mem_q[wr_ptr_q] <= {in_s_tlast, in_s_tdata};
  end

  assign out_s_tready   = s_rdy_q;
  assign out_m_tvalid   = m_vld_q;
  assign out_m_tdata    = head[pDATA_WIDTH-1:0];
  assign out_m_tlast    = head[pDATA_WIDTH];
  assign out_level      = level_q;
  assign out_frame_cnt  = fcnt_q;
  assign out_frame_done = fdone_q;

endmodule

// File: tb/tb_fir_ss_fifo.sv
// Randomized bench for fir_ss_fifo against a queue-based reference model.
module tb_fir_ss_fifo;
  localparam int W  = 32;
  localparam int DL = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          in_flush = 1'b0;
  logic          in_s_tvalid = 1'b0;
  logic [W-1:0]  in_s_tdata = '0;
  logic          in_s_tlast = 1'b0;
  logic          in_m_tready = 1'b0;
  logic          out_s_tready, out_m_tvalid, out_m_tlast, out_frame_done;
  logic [W-1:0]  out_m_tdata;
  logic [DL:0]   out_level;
  logic [15:0]   out_frame_cnt;

  fir_ss_fifo #(.pDATA_WIDTH(W), .DEPTH_LOG2(DL)) dut (
    .aclk(aclk), .aresetn(aresetn), .in_flush(in_flush),
    .in_s_tvalid(in_s_tvalid), .in_s_tdata(in_s_tdata), .in_s_tlast(in_s_tlast),
    .out_s_tready(out_s_tready), .out_m_tvalid(out_m_tvalid),
    .out_m_tdata(out_m_tdata), .out_m_tlast(out_m_tlast), .in_m_tready(in_m_tready),
    .out_level(out_level), .out_frame_cnt(out_frame_cnt), .out_frame_done(out_frame_done)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  // Reference model: FIFO contents as a queue of {tlast,data}
  logic [W:0] q[$];
  logic [W:0] dutq[$];
  int m_fcnt = 0;
  bit m_done = 0;
  bit m_ready = 0;
  bit last_push, last_pop;

  task automatic edge_step();
    bit push, pop;
    logic [W:0] h;
    push = in_s_tvalid && m_ready;
    pop  = (q.size() != 0) && in_m_tready;
    if (out_m_tvalid && in_m_tready) dutq.push_back({out_m_tlast, out_m_tdata});
    @(posedge aclk);
    last_push = 0;
    last_pop  = 0;
    if (!aresetn) begin
      q.delete(); m_fcnt = 0; m_done = 0; m_ready = 0;
    end else if (in_flush) begin
      q.delete(); m_fcnt = 0; m_done = 0; m_ready = 1;
    end else begin
      m_done = 0;
      if (pop) begin
        h = q.pop_front();
        last_pop = 1;
        if (h[W]) begin m_fcnt = 0; m_done = 1; end
        else if (m_fcnt < 65535) m_fcnt++;
      end
      if (push) begin
        q.push_back({in_s_tlast, in_s_tdata});
        last_push = 1;
      end
      m_ready = (q.size() < 16);
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (3) edge_step();
    checks++; if (out_level !== '0 || out_m_tvalid !== 1'b0 || out_s_tready !== 1'b0) begin
      failures++; $display("FAIL reset_hold level=%0d vld=%b rdy=%b required 0/0/0", out_level, out_m_tvalid, out_s_tready);
    end
    aresetn = 1'b1;
    edge_step();
    checks++; if (out_s_tready !== 1'b1) begin
      failures++; $display("FAIL reset_release_rdy got=%b required 1", out_s_tready);
    end
    in_m_tready = 1'b0;
    in_s_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_s_tdata = $urandom;
      edge_step();
    end
    in_s_tvalid = 1'b0;
    checks++; if (out_level !== 5'd5) begin
      failures++; $display("FAIL reset_prefill level got=%0d required 5", out_level);
    end
    #2 aresetn = 1'b0;
    q.delete(); m_fcnt = 0; m_done = 0; m_ready = 0;
    #1;
    checks++; if (out_level !== '0 || out_m_tvalid !== 1'b0 || out_s_tready !== 1'b0) begin
      failures++; $display("FAIL reset_async level=%0d vld=%b rdy=%b required 0/0/0", out_level, out_m_tvalid, out_s_tready);
    end
    repeat (2) edge_step();
    aresetn = 1'b1;
    checks++; if (out_s_tready !== 1'b0) begin
      failures++; $display("FAIL reset_rdy_before_edge got=%b required 0", out_s_tready);
    end
    edge_step();
    checks++; if (out_s_tready !== 1'b1 || out_level !== '0 || out_m_tvalid !== 1'b0) begin
      failures++; $display("FAIL reset_after_edge rdy=%b level=%0d vld=%b required 1/0/0", out_s_tready, out_level, out_m_tvalid);
    end
  endtask

  task automatic test_fill();
    dutq.delete();
    in_m_tready = 1'b0;
    in_s_tvalid = 1'b1;
    in_s_tlast  = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      in_s_tdata = W'(i);
      edge_step();
    end
    checks++; if (out_level !== 5'd16 || out_s_tready !== 1'b0) begin
      failures++; $display("FAIL fill_full level=%0d rdy=%b required 16/0", out_level, out_s_tready);
    end
    in_s_tdata = W'(17);
    repeat (3) edge_step();
    checks++; if (out_level !== 5'd16 || out_m_tdata !== W'(1)) begin
      failures++; $display("FAIL fill_hold level=%0d head=%0d required 16/1", out_level, out_m_tdata);
    end
    in_m_tready = 1'b1;
    edge_step();
    checks++; if (out_s_tready !== 1'b1 || out_level !== 5'd15) begin
      failures++; $display("FAIL fill_rdy_rise rdy=%b level=%0d required 1/15", out_s_tready, out_level);
    end
    for (int c = 0; c < 60 && dutq.size() < 17; c++) begin
      edge_step();
      if (last_push) in_s_tvalid = 1'b0;
    end
    in_s_tvalid = 1'b0;
    checks++; if (dutq.size() != 17) begin
      failures++; $display("FAIL fill_count got=%0d required 17", dutq.size());
    end
    for (int i = 0; i < dutq.size(); i++) begin
      checks++; if (dutq[i] !== {1'b0, W'(i + 1)}) begin
        failures++; $display("FAIL fill_order[%0d] got=%0h required %0h", i, dutq[i], i + 1);
      end
    end
  endtask

  task automatic test_streaming();
    logic [W:0] expv [600];
    int idx = 0;
    for (int i = 0; i < 600; i++) begin
      int t, v;
      t = i % 200;
      v = ((t < 100) ? t : 200 - t) * 1234 - 60000;
      expv[i] = {(i == 599), W'(v)};
    end
    dutq.delete();
    for (int c = 0; c < 20000 && dutq.size() < 600; c++) begin
      in_m_tready = ($urandom_range(0, 10) == 0);
      if (idx < 600) begin
        in_s_tvalid = 1'b1;
        {in_s_tlast, in_s_tdata} = expv[idx];
      end else begin
        in_s_tvalid = 1'b0;
      end
      edge_step();
      if (last_push) idx++;
      checks++; if (out_level !== 5'(q.size()) || out_s_tready !== m_ready) begin
        failures++; $display("FAIL stream_level got=%0d/%b required %0d/%b", out_level, out_s_tready, q.size(), m_ready);
      end
      checks++; if (out_frame_cnt !== 16'(m_fcnt)) begin
        failures++; $display("FAIL stream_fcnt got=%0d required %0d", out_frame_cnt, m_fcnt);
      end
      if (q.size() != 0) begin
        checks++; if (out_m_tvalid !== 1'b1 || {out_m_tlast, out_m_tdata} !== q[0]) begin
          failures++; $display("FAIL stream_head got=%b/%0h required 1/%0h", out_m_tvalid, {out_m_tlast, out_m_tdata}, q[0]);
        end
      end
    end
    in_s_tvalid = 1'b0;
    in_s_tlast  = 1'b0;
    checks++; if (dutq.size() != 600) begin
      failures++; $display("FAIL stream_count got=%0d required 600", dutq.size());
    end
    for (int i = 0; i < dutq.size() && i < 600; i++) begin
      checks++; if (dutq[i] !== expv[i]) begin
        failures++; $display("FAIL stream_data[%0d] got=%0h required %0h", i, dutq[i], expv[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [W:0] sq[$];
    dutq.delete();
    in_m_tready = 1'b0;
    in_s_tvalid = 1'b1;
    in_s_tlast  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_s_tdata = $urandom;
      sq.push_back({1'b0, in_s_tdata});
      edge_step();
    end
    in_m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_s_tdata = $urandom;
      sq.push_back({1'b0, in_s_tdata});
      edge_step();
      checks++; if (out_level !== 5'd3 || out_m_tvalid !== 1'b1) begin
        failures++; $display("FAIL simul_level[%0d] got=%0d/%b required 3/1", i, out_level, out_m_tvalid);
      end
    end
    in_s_tvalid = 1'b0;
    for (int c = 0; c < 20 && dutq.size() < sq.size(); c++) edge_step();
    checks++; if (dutq.size() != sq.size()) begin
      failures++; $display("FAIL simul_count got=%0d required %0d", dutq.size(), sq.size());
    end
    for (int i = 0; i < dutq.size() && i < sq.size(); i++) begin
      checks++; if (dutq[i] !== sq[i]) begin
        failures++; $display("FAIL simul_data[%0d] got=%0h required %0h", i, dutq[i], sq[i]);
      end
    end
  endtask

  task automatic test_frame();
    int maxcnt = 0;
    int dones = 0;
    in_flush = 1'b1;
    edge_step();
    in_flush = 1'b0;
    in_m_tready = 1'b0;
    in_s_tvalid = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      in_s_tdata = $urandom;
      in_s_tlast = (i == 11);
      edge_step();
    end
    in_s_tvalid = 1'b0;
    in_s_tlast  = 1'b0;
    in_m_tready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      edge_step();
      if (int'(out_frame_cnt) > maxcnt) maxcnt = int'(out_frame_cnt);
      if (out_frame_done === 1'b1) dones++;
      checks++; if (out_frame_cnt !== 16'(m_fcnt) || out_frame_done !== m_done) begin
        failures++; $display("FAIL frame_step[%0d] got=%0d/%b required %0d/%b", c, out_frame_cnt, out_frame_done, m_fcnt, m_done);
      end
    end
    checks++; if (maxcnt != 10 || dones != 1 || out_frame_cnt !== 16'd0) begin
      failures++; $display("FAIL frame_summary max=%0d dones=%0d cnt=%0d required 10/1/0", maxcnt, dones, out_frame_cnt);
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] x;
    in_m_tready = 1'b0;
    in_s_tvalid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_s_tdata = $urandom;
      edge_step();
    end
    checks++; if (out_level !== 5'd9) begin
      failures++; $display("FAIL flush_prefill level got=%0d required 9", out_level);
    end
    in_flush    = 1'b1;
    in_s_tdata  = 32'hDEAD_BEEF;
    in_m_tready = 1'b1;
    edge_step();
    in_flush    = 1'b0;
    in_s_tvalid = 1'b0;
    in_m_tready = 1'b0;
    checks++; if (out_level !== '0 || out_m_tvalid !== 1'b0 || out_s_tready !== 1'b1 || out_frame_cnt !== '0) begin
      failures++; $display("FAIL flush_clear level=%0d vld=%b rdy=%b cnt=%0d required 0/0/1/0", out_level, out_m_tvalid, out_s_tready, out_frame_cnt);
    end
    x = $urandom;
    in_s_tdata  = x;
    in_s_tvalid = 1'b1;
    edge_step();
    in_s_tvalid = 1'b0;
    dutq.delete();
    in_m_tready = 1'b1;
    for (int c = 0; c < 10 && dutq.size() < 1; c++) edge_step();
    checks++; if (dutq.size() < 1 || dutq[0] !== {1'b0, x}) begin
      failures++; $display("FAIL flush_first got=%0h required %0h", (dutq.size() > 0) ? dutq[0] : '0, x);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_streaming();
    test_simultaneous();
    test_frame();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
